// File: rtl/subleq_prog_loader_if.sv
// Stream-in and RAM-write bus for the SUBLEQ boot loader.
// The master side is the loader: it consumes the byte stream and drives the RAM write port.
interface subleq_prog_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_dat;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ram_we,
        output ram_adr,
        output ram_dat
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ram_we,
        input  ram_adr,
        input  ram_dat
    );
endinterface

// File: rtl/subleq_prog_loader.sv
// Boot loader for the SUBLEQ machine: streams a length-prefixed image into RAM,
// verifies the trailing checksum and only then releases the CPU from reset.
module subleq_prog_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned WR_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    subleq_prog_loader_if.master bus,
    output logic                 cpu_res,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StChk,
        StRun,
        StErr
    } state_e;

    localparam logic [ADDR_W-1:0] Base      = ADDR_W'(BASE_ADDR);
    localparam logic [1:0]        WcLast    = 2'(WR_CYCLES - 1);
    // A zero LEN byte encodes a full 2^ADDR_W-word image.
    localparam logic [ADDR_W:0]   FullCount = {1'b1, {ADDR_W{1'b0}}};

    state_e            state;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] sum;
    logic [1:0]        wcnt;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_adr;
    logic [DATA_W-1:0] ram_dat;
    logic              xfer;

    assign xfer         = bus.in_valid && in_ready;
    assign bus.in_ready = in_ready;
    assign bus.ram_we   = ram_we;
    assign bus.ram_adr  = ram_adr;
    assign bus.ram_dat  = ram_dat;

    always_ff @(posedge clk) begin
        if (!res) begin
            state    <= StIdle;
            count    <= '0;
            sum      <= '0;
            wcnt     <= '0;
            in_ready <= 1'b0;
            ram_we   <= 1'b0;
            ram_adr  <= Base;
            ram_dat  <= '0;
            cpu_res  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                // busy is low in all three resting states, so start is only honoured here
                StIdle, StRun, StErr: begin
                    if (start) begin
                        state    <= StLen;
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        done     <= 1'b0;
                        cpu_res  <= 1'b0;
                        sum      <= '0;
                        ram_adr  <= Base;
                        in_ready <= 1'b1;
                    end
                end
                StLen: begin
                    if (xfer) begin
                        count <= (bus.in_data == '0) ? FullCount : (ADDR_W + 1)'(bus.in_data);
                        state <= StData;
                    end
                end
                StData: begin
                    if (xfer) begin
                        ram_dat  <= bus.in_data;
                        sum      <= sum + bus.in_data;
                        in_ready <= 1'b0;
                        ram_we   <= 1'b1;
                        wcnt     <= '0;
                        state    <= StWrite;
                    end
                end
                StWrite: begin
                    if (wcnt == WcLast) begin
                        ram_we   <= 1'b0;
                        ram_adr  <= ram_adr + ADDR_W'(1);
                        count    <= count - (ADDR_W + 1)'(1);
                        in_ready <= 1'b1;
                        state    <= (count == (ADDR_W + 1)'(1)) ? StChk : StData;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                StChk: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (bus.in_data == sum) begin
                            state   <= StRun;
                            done    <= 1'b1;
                            cpu_res <= 1'b1;
                        end else begin
                            state <= StErr;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_subleq_prog_loader.sv
// Directed bench for subleq_prog_loader: one instance with single-cycle writes,
// one with three-cycle writes and a toggling source.
module tb_subleq_prog_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res    = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    logic cpu_res1, busy1, done1, err1;
    logic cpu_res3, busy3, done3, err3;

    subleq_prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
    subleq_prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

    subleq_prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0), .WR_CYCLES(1)) u_dut1 (
        .clk     (clk),
        .res     (res),
        .start   (start1),
        .bus     (bus1),
        .cpu_res (cpu_res1),
        .busy    (busy1),
        .done    (done1),
        .err     (err1)
    );

    subleq_prog_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(0), .WR_CYCLES(3)) u_dut3 (
        .clk     (clk),
        .res     (res),
        .start   (start3),
        .bus     (bus3),
        .cpu_res (cpu_res3),
        .busy    (busy3),
        .done    (done3),
        .err     (err3)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] wq1[$];
    logic [15:0] wq3[$];
    int          run1     = 0;
    int          run3     = 0;
    bit          tog      = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitors: log (adr,dat) per pulse, check pulse length and stability.
    always @(negedge clk) begin
        if (bus1.ram_we) begin
            check("rdy_we1", 32'(bus1.in_ready), 0);
            if (run1 == 0) wq1.push_back({bus1.ram_adr, bus1.ram_dat});
            else check("stable1", 32'({bus1.ram_adr, bus1.ram_dat}), 32'(wq1[$]));
            run1++;
        end else if (run1 != 0) begin
            check("pulse1", run1, 1);
            run1 = 0;
        end
    end

    always @(negedge clk) begin
        if (bus3.ram_we) begin
            check("rdy_we3", 32'(bus3.in_ready), 0);
            if (run3 == 0) wq3.push_back({bus3.ram_adr, bus3.ram_dat});
            else check("stable3", 32'({bus3.ram_adr, bus3.ram_dat}), 32'(wq3[$]));
            run3++;
        end else if (run3 != 0) begin
            check("pulse3", run3, 3);
            run3 = 0;
        end
    end

    task automatic send1(input logic [7:0] b);
        bit ok = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = b;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (bus1.in_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus1.in_valid = 1'b0;
        if (!ok) check("timeout1", 1, 0);
    endtask

    task automatic send3(input logic [7:0] b);
        bit ok = 1'b0;
        bus3.in_data = b;
        for (int n = 0; n < 40 && !ok; n++) begin
            tog = ~tog;
            bus3.in_valid = tog;
            if (tog && bus3.in_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus3.in_valid = 1'b0;
        if (!ok) check("timeout3", 1, 0);
    endtask

    task automatic pulse1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic check_reset1();
        check("rst_rdy", 32'(bus1.in_ready), 0);
        check("rst_we", 32'(bus1.ram_we), 0);
        check("rst_adr", 32'(bus1.ram_adr), 0);
        check("rst_dat", 32'(bus1.ram_dat), 0);
        check("rst_cpu", 32'(cpu_res1), 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        check("rst_err", 32'(err1), 0);
    endtask

    initial begin
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;
        bus3.in_valid = 1'b0;
        bus3.in_data  = '0;
        repeat (2) @(negedge clk);
        check_reset1();
        check("rst_cpu3", 32'(cpu_res3), 0);
        res = 1'b1;
        @(negedge clk);

        // Good 3-byte image
        pulse1();
        check("t1_busy", 32'(busy1), 1);
        check("t1_rdy", 32'(bus1.in_ready), 1);
        send1(8'd3); send1(8'h05); send1(8'h0A); send1(8'hFF);
        check("t1_done_pre", 32'(done1), 0);
        send1(8'h0E);
        check("t1_done", 32'(done1), 1);
        check("t1_cpu", 32'(cpu_res1), 1);
        check("t1_err", 32'(err1), 0);
        check("t1_busy_end", 32'(busy1), 0);
        check("t1_n", wq1.size(), 3);
        if (wq1.size() == 3) begin
            check("t1_w0", 32'(wq1[0]), 32'h0005);
            check("t1_w1", 32'(wq1[1]), 32'h010A);
            check("t1_w2", 32'(wq1[2]), 32'h02FF);
        end
        wq1.delete();

        // Start while running drops cpu_res, then bad checksum
        pulse1();
        check("t7_cpu", 32'(cpu_res1), 0);
        check("t7_done", 32'(done1), 0);
        check("t7_rdy", 32'(bus1.in_ready), 1);
        check("t7_busy", 32'(busy1), 1);
        send1(8'd3); send1(8'h05); send1(8'h0A); send1(8'hFF); send1(8'h0F);
        check("t2_err", 32'(err1), 1);
        check("t2_cpu", 32'(cpu_res1), 0);
        check("t2_done", 32'(done1), 0);
        check("t2_n", wq1.size(), 3);
        if (wq1.size() == 3) check("t2_w2", 32'(wq1[2]), 32'h02FF);
        wq1.delete();

        // Restart from ERR; start pulses while busy are ignored
        pulse1();
        check("t6_err_clr", 32'(err1), 0);
        send1(8'd2);
        pulse1();
        check("t6_busy", 32'(busy1), 1);
        send1(8'h10);
        pulse1();
        send1(8'h20); send1(8'h30);
        check("t6_done", 32'(done1), 1);
        check("t6_err", 32'(err1), 0);
        check("t6_n", wq1.size(), 2);
        if (wq1.size() == 2) begin
            check("t6_w0", 32'(wq1[0]), 32'h0010);
            check("t6_w1", 32'(wq1[1]), 32'h0120);
        end
        wq1.delete();

        // Full 256-word image, address wraps
        pulse1();
        send1(8'd0);
        for (int i = 0; i < 256; i++) send1(8'(i));
        send1(8'h80);
        check("t3_done", 32'(done1), 1);
        check("t3_n", wq1.size(), 256);
        check("t3_adr_wrap", 32'(bus1.ram_adr), 0);
        begin
            int bad = 0;
            foreach (wq1[i]) if (wq1[i] != {8'(i), 8'(i)}) bad++;
            check("t3_data", bad, 0);
        end
        wq1.delete();

        // Three-cycle writes with a toggling source
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        send3(8'd3); send3(8'h11); send3(8'h22); send3(8'h33); send3(8'h66);
        check("t4_done", 32'(done3), 1);
        check("t4_n", wq3.size(), 3);
        if (wq3.size() == 3) begin
            check("t4_w0", 32'(wq3[0]), 32'h0011);
            check("t4_w1", 32'(wq3[1]), 32'h0122);
            check("t4_w2", 32'(wq3[2]), 32'h0233);
        end

        // Reset in the middle of a load
        pulse1();
        send1(8'd4); send1(8'h01); send1(8'h02);
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
        check_reset1();
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'h03;
        repeat (6) @(negedge clk);
        bus1.in_valid = 1'b0;
        check("t5_nowr", wq1.size(), 2);
        pulse1();
        send1(8'd1); send1(8'h33); send1(8'h33);
        check("t5_done", 32'(done1), 1);
        check("t5_n", wq1.size(), 3);
        if (wq1.size() == 3) check("t5_w", 32'(wq1[2]), 32'h0033);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/subleq_prog_loader.md
Name: subleq_prog_loader

Overview:
- Upstream boot stage for the SUBLEQ machine.
- Holds the CPU in reset, accepts a byte stream over a valid/ready handshake, writes the program image into RAM starting at BASE_ADDR, and verifies a trailing checksum.
- On a checksum match it releases the CPU reset so that execution begins from PC = 0.
- Owns the RAM write port while loading and drives nothing once in RUN.

Parameters:
- ADDR_W, 8, RAM address width. The address wraps modulo 2^ADDR_W.
- DATA_W, 8, RAM word and stream byte width.
- BASE_ADDR, 0, first RAM address written.
- WR_CYCLES, 1, number of cycles ram_we is held per word (1..4).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- res  in  1  reset; synchronous and active-low.
- start  in  1  single-cycle pulse that begins a load.
- in_valid  in  1  in_data is valid.
- in_data  in  DATA_W  stream byte.
- in_ready  out  1  loader accepts in_data this cycle.
- ram_we  out  1  RAM write strobe.
- ram_adr  out  ADDR_W  RAM write address.
- ram_dat  out  DATA_W  RAM write data.
- cpu_res  out  1  active-low reset to the CPU (PC, control_unit, registers).
- busy  out  1  a load is in progress.
- done  out  1  image loaded and checksum OK; CPU running.
- err  out  1  checksum mismatch; CPU held in reset.

Behaviour:
- All outputs are registered. A byte transfers when in_valid && in_ready at a rising edge.
- Reset values (res low at an edge): state IDLE, in_ready 0, ram_we 0, ram_adr BASE_ADDR, ram_dat 0, cpu_res 0, busy 0, done 0, err 0, count 0, sum 0.
- Reset mid-load: reset aborts immediately. No further ram_we is issued.
- Stream format:
  - LEN byte: L. L = 0 means 2^ADDR_W words.
  - L data bytes.
  - CHK byte: the sum of the data bytes mod 2^DATA_W.
- States:
  - IDLE:
    - in_ready 0, cpu_res 0.
    - On start: go to LEN, busy 1, err 0, sum 0, ram_adr BASE_ADDR.
  - LEN:
    - in_ready 1.
    - On transfer: count = (L == 0 ? 2^ADDR_W : L), which needs an ADDR_W+1-bit counter; go to DATA.
  - DATA:
    - in_ready 1.
    - On transfer: ram_dat = in_data, sum += in_data (wrapping); go to WRITE.
  - WRITE:
    - in_ready 0. ram_we is 1 for exactly WR_CYCLES cycles; ram_adr and ram_dat are stable throughout.
    - After the last write cycle: ram_we 0, ram_adr increments (wrapping mod 2^ADDR_W), count decrements.
    - If the new count is 0, go to CHK; otherwise go to DATA.
  - CHK:
    - in_ready 1.
    - On transfer, match (in_data == sum): go to RUN, done 1, busy 0, cpu_res 1 on the same edge.
    - On transfer, mismatch: go to ERR, err 1, busy 0.
  - RUN:
    - cpu_res 1, done 1, in_ready 0, ram_we 0.
    - start: go to LEN; cpu_res 0 and done 0 on the next edge.
  - ERR:
    - cpu_res 0, err 1.
    - start: go to LEN; err clears.
- start is ignored while busy = 1.
- in_valid while in_ready = 0 has no effect. The source must hold its data.
- No timeout: an idle stream stalls the loader indefinitely.
- Minimum load time is 2 + L·(1 + WR_CYCLES) + 1 cycles after start, with in_valid held high.

Test Plan:
1. start, stream L=3, 0x05, 0x0A, 0xFF, CHK 0x0E:
   - ram_we pulses with (adr, dat) = (0,0x05), (1,0x0A), (2,0xFF).
   - done = 1, cpu_res = 1 on the edge accepting CHK; err = 0.
2. Same stream with CHK 0x0F:
   - All 3 writes occur; err = 1, cpu_res stays 0, done = 0.
   - A subsequent start followed by a correct stream gives done = 1 and err = 0.
3. L=0 with 256 bytes of value i, BASE_ADDR=0, CHK 0x80:
   - 256 writes; ram_adr wraps 0xFF→0x00; done = 1.
4. in_valid toggled 1/0 each cycle and WR_CYCLES = 3:
   - in_ready is never 1 while ram_we = 1.
   - Each ram_we pulse is exactly 3 cycles; data is written in order.
5. res low for one edge after the second data byte:
   - All outputs return to reset values; no further ram_we.
   - start afterwards restarts from BASE_ADDR.
6. start pulsed while busy:
   - Ignored.
7. start pulsed in RUN:
   - cpu_res falls on the next edge; the loader accepts a new LEN byte.
